x_delay_line_ctrl: RTL and testbench

Measurement controller at the launch/readout end of the FPGA delay line. It drives the launch edge into tap 0 of the chain of delay cells. It waits out the cells' metastability resolvers, then captures the resolved tap vector and decodes it into an edge-position count with bubble and overflow flags. The result is returned over a valid/ready interface to the host logic (UART/readout path).

---
 rtl/x_delay_line_ctrl.sv | 143 ++++++++++++++
 tb/tb_x_delay_line_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/x_delay_line_ctrl.sv
// Launch/readout controller for the FPGA delay line: fires the launch edge, waits out
// the cell resolvers, captures the tap vector and returns popcount/bubble/overflow.
module x_delay_line_ctrl #(
  parameter int p_taps = 64,
  parameter int p_sync = 4,
  parameter int p_cw   = $clog2(p_taps + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_launch,
  input  logic [p_taps-1:0] i_taps,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [p_cw-1:0]   o_count,
  output logic              o_bubble,
  output logic              o_ovf
);

  localparam int LP_CNTW = $clog2(p_sync + 2);
  localparam logic [LP_CNTW-1:0] LP_LAST  = LP_CNTW'(p_sync);
  localparam logic [LP_CNTW-1:0] LP_CINC  = LP_CNTW'(1);
  localparam logic [p_taps-1:0]  LP_TINC  = {{(p_taps-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ENCODE,
    S_OUT,
    S_DRAIN
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [LP_CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic                r_launch, w_launch_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy;
  logic                w_cap_ld, w_enc;
  logic [p_taps-1:0]   r_cap;
  logic [p_cw-1:0]     r_count, w_pop;
  logic                r_bubble, w_bubble;
  logic                r_ovf, w_ovf;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_launch_nxt = r_launch;
    w_valid_nxt  = r_valid;
    w_cap_ld     = 1'b0;
    w_enc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_launch_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == LP_LAST) begin
          w_cap_ld    = 1'b1;
          w_state_nxt = S_ENCODE;
        end else begin
          w_cnt_nxt = r_cnt + LP_CINC;
        end
      end
      S_ENCODE: begin
        w_enc       = 1'b1;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_ready) begin
          w_valid_nxt  = 1'b0;
          w_launch_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == LP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + LP_CINC;
        end
      end
      default: begin
        w_launch_nxt = 1'b0;
        w_valid_nxt  = 1'b0;
        w_cnt_nxt    = '0;
        w_state_nxt  = S_DRAIN;
      end
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < p_taps; i++) begin
      w_pop = w_pop + p_cw'(r_cap[i]);
    end
  end

  // A clean 0..01..1 code plus one is a power of two, so it shares no set bit with itself.
  assign w_bubble = |(r_cap & (r_cap + LP_TINC));
  assign w_ovf    = &r_cap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_DRAIN;
      r_cnt    <= '0;
      r_launch <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b1;
      r_cap    <= '0;
      r_count  <= '0;
      r_bubble <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_launch <= w_launch_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_cap_ld) begin
        r_cap <= i_taps;
      end
      if (w_enc) begin
        r_count  <= w_pop;
        r_bubble <= w_bubble;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_launch = r_launch;
  assign o_valid  = r_valid;
  assign o_count  = r_count;
  assign o_bubble = r_bubble;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Directed + randomized bench for x_delay_line_ctrl against a cycle-level reference
// built from the measurement timeline and plain bit arithmetic on the tap vector.
module tb_x_delay_line_ctrl;

  localparam int TAPS = 64;
  localparam int SYNC = 4;
  localparam int CW   = $clog2(TAPS + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            launch;
  logic [TAPS-1:0] taps;
  logic            valid;
  logic            ready;
  logic [CW-1:0]   count;
  logic            bubble;
  logic            ovf;

  int n_vec = 0;
  int n_err = 0;

  x_delay_line_ctrl #(
    .p_taps (TAPS),
    .p_sync (SYNC)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .o_busy   (busy),
    .o_launch (launch),
    .i_taps   (taps),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_count  (count),
    .o_bubble (bubble),
    .o_ovf    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count(input logic [TAPS-1:0] t);
    int c = 0;
    for (int i = 0; i < TAPS; i++) if (t[i]) c++;
    return c;
  endfunction

  function automatic bit m_bubble(input logic [TAPS-1:0] t);
    for (int i = 0; i < TAPS; i++)
      for (int j = i + 1; j < TAPS; j++)
        if (!t[i] && t[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ovf(input logic [TAPS-1:0] t);
    for (int i = 0; i < TAPS; i++) if (!t[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [TAPS-1:0] gen_taps();
    int unsigned     mode = $urandom_range(0, 2);
    int unsigned     n    = $urandom_range(0, TAPS);
    logic [TAPS-1:0] t;
    t = (n == TAPS) ? '1 : ((64'd1 << n) - 64'd1);
    if (mode == 1) t = t ^ (64'd1 << $urandom_range(0, TAPS - 1));
    if (mode == 2) t = {$urandom, $urandom};
    return t;
  endfunction

  // One full measurement: E0 start, capture at E(SYNC+1), valid after E(SYNC+2),
  // 'w' stall cycles, handshake, SYNC+1 drain edges, then idle.
  task automatic measure(input logic [TAPS-1:0] t, input int w);
    int ec = m_count(t);
    bit eb = m_bubble(t);
    bit eo = m_ovf(t);
    start = 1'b1;
    ready = (w == 0);
    tick();
    start = 1'b0;
    taps  = t;
    chk("launch_E0", launch, 1);
    chk("busy_E0", busy, 1);
    chk("valid_E0", valid, 0);
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      chk("valid_settle", valid, 0);
      chk("launch_settle", launch, 1);
    end
    tick();
    chk("valid_rise", valid, 1);
    chk("count", count, ec);
    chk("bubble", bubble, eb);
    chk("ovf", ovf, eo);
    for (int k = 0; k < w; k++) begin
      ready = 1'b0;
      taps  = {$urandom, $urandom};
      start = k[0];
      tick();
      chk("valid_stall", valid, 1);
      chk("count_stall", count, ec);
      chk("bubble_stall", bubble, eb);
      chk("ovf_stall", ovf, eo);
      chk("launch_stall", launch, 1);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("valid_hs", valid, 0);
    chk("launch_hs", launch, 0);
    chk("busy_hs", busy, 1);
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      chk("busy_drain", busy, (k <= SYNC) ? 1 : 0);
      chk("valid_drain", valid, 0);
      chk("launch_drain", launch, 0);
      chk("count_hold", count, ec);
    end
    tick();
    chk("launch_idle", launch, 0);
    chk("busy_idle", busy, 0);
    chk("valid_idle", valid, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    taps  = '1;
    #2;
    chk("rst_launch", launch, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_count", count, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_ovf", ovf, 0);
    tick();
    tick();
    chk("rst_hold_busy", busy, 1);
    rst   = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      chk("post_rst_busy", busy, (k <= SYNC) ? 1 : 0);
      chk("post_rst_launch", launch, 0);
      chk("post_rst_valid", valid, 0);
    end
    start = 1'b0;
    tick();
    chk("post_rst_idle_launch", launch, 0);
    chk("post_rst_idle_busy", busy, 0);

    measure(64'h0000_0000_0000_00FF, 0);
    measure(64'h0000_0000_0000_00F7, 0);
    measure(64'h0000_0000_0000_0000, 0);
    measure('1, 0);
    measure(64'h0000_00FF_FFFF_FFFF, 10);

    start = 1'b1;
    tick();
    start = 1'b0;
    taps  = 64'h0000_0000_0000_FFFF;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_launch", launch, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 1);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      chk("midrst_drain_busy", busy, (k <= SYNC) ? 1 : 0);
      chk("midrst_drain_valid", valid, 0);
      chk("midrst_drain_launch", launch, 0);
    end
    measure(64'h0000_0000_0FFF_FFFF, 0);

    for (int r = 0; r < 25; r++) begin
      measure(gen_taps(), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
